r_rom_backend: RTL
==================

R_ROM_BACKEND -- requirements
Module: r_rom_backend

Interface
REQ-001 Parameter: BYTES, 8, number of address bytes per command and data bytes per response.
REQ-002 Parameter: AW, 64, memory address width; AW == 8*BYTES.
REQ-003 Parameter: DW, 64, memory data width; DW == 8*BYTES.
REQ-004 Port: clk  input  1  single clock for the whole block; one clock domain only.
REQ-005 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-006 Port: empty  input  1  command FIFO empty.
REQ-007 Port: rd_en  output  1  command FIFO read strobe.
REQ-008 Port: dout  input  8  command FIFO read data; valid on the cycle after a cycle with rd_en=1 and empty=0.
REQ-009 Port: full  input  1  response FIFO full.
REQ-010 Port: wr_en  output  1  response FIFO write strobe.
REQ-011 Port: din  output  8  response FIFO write data.
REQ-012 Port: mem_req  output  1  ROM read request, held until acknowledged.
REQ-013 Port: mem_addr  output  AW  ROM read address.
REQ-014 Port: mem_ack  input  1  ROM read done; mem_rdata valid in the same cycle.
REQ-015 Port: mem_rdata  input  DW  ROM read data.
REQ-016 Port: busy  output  1  high in every state except S_CMD with zero bytes requested.

Function
REQ-017 The FSM SHALL have exactly three states: S_CMD (collect address), S_MEM (ROM access) and S_RSP (emit data).
REQ-018 In S_CMD, rd_en SHALL be combinational: (state==S_CMD) & ~empty & (req_cnt < BYTES). req_cnt is a 4-bit count of issued reads.
REQ-019 A 1-cycle flag rd_vld SHALL record rd_en & ~empty; when rd_vld=1, dout SHALL be shifted in LSB-first: addr <= {dout, addr[AW-1:8]}, and cap_cnt increments.
REQ-020 Gaps (empty=1) SHALL stall collection without losing or duplicating bytes; at most BYTES reads SHALL be issued per command.
REQ-021 The cycle after the BYTES-th byte is captured, the state SHALL be S_MEM and mem_req=1, with mem_addr equal to the assembled address.
REQ-022 mem_req and mem_addr SHALL stay stable until mem_ack=1. An ack in the first S_MEM cycle SHALL be accepted. mem_ack outside S_MEM SHALL be ignored.
REQ-023 On an accepted ack, mem_rdata SHALL be latched into a shift register, the byte counter SHALL be cleared, and the next state SHALL be S_RSP.
REQ-024 In S_RSP, wr_en SHALL be combinational: (state==S_RSP) & ~full, with din = shift[7:0]. On each write the shift register SHALL shift right by 8 and the counter SHALL increment.
REQ-025 full=1 SHALL stall emission with din held. Bytes SHALL go out LSB-first, exactly BYTES per response.
REQ-026 After the BYTES-th write, the state SHALL return to S_CMD and both counters SHALL clear. Back-to-back commands SHALL need no idle cycle beyond this transition.
REQ-027 Latency: the first wr_en SHALL come no earlier than the cycle after mem_ack, provided full=0.
REQ-028 Counters SHALL never wrap past BYTES; byte index overflow SHALL be impossible by construction.

Reset
REQ-029 While rst_n=0 at a clk edge, the block SHALL reset: state=S_CMD; req_cnt, cap_cnt, rd_vld, addr and shift all 0.
REQ-030 While rst_n=0, outputs SHALL be: rd_en=0, wr_en=0, din=0, mem_req=0, mem_addr=0, busy=0.
REQ-031 Reset mid-operation SHALL discard any partial command, pending read data or response. A mem_ack arriving after reset SHALL be ignored.

Structure
REQ-032 Package r_rom_pkg SHALL hold the state enum (S_CMD, S_MEM, S_RSP) and the R_ROM_BYTES constant; the bench SHALL share this package.
REQ-033 A single sub-module, r_rom_shifter, SHALL implement the byte shift register. It SHALL be instantiated twice: as the address deserializer and as the data serializer.
REQ-034 All flops SHALL use the codebase dff primitive or equivalent synchronous-reset always blocks; there SHALL be no latches.

Verification
REQ-035 Basic transaction:
- Stimulus: command bytes 00 10 00 80 00 00 00 00, contiguous; mem_ack one cycle after mem_req; mem_rdata=0x1122334455667788.
- Response: mem_addr=0x0000000080001000; din sequence 88 77 66 55 44 33 22 11.
REQ-036 Command gaps:
- Stimulus: empty toggles every other cycle during the same command.
- Response: identical mem_addr; exactly 8 rd_en pulses.
REQ-037 ROM wait:
- Stimulus: mem_ack delayed 5 cycles.
- Response: mem_req and mem_addr stable for 6 cycles; one latch only.
REQ-038 Response backpressure:
- Stimulus: full=1 for 4 cycles after the 3rd data byte.
- Response: no wr_en while full=1; din=0x55 held; all 8 bytes delivered in order.
REQ-039 Reset mid-command:
- Stimulus: rst_n low for 2 cycles after 3 command bytes; then a full new command 08 00 00 00 00 00 00 00.
- Response: mem_addr=0x8; no stale bytes.
REQ-040 Back-to-back:
- Stimulus: two commands queued in the command FIFO.
- Response: two responses of 8 bytes each, in order; busy low only between them.

Source files
------------

// File: rtl/r_rom_pkg.sv
// Shared definitions for the ROM read backend: FSM state encoding and default byte count.
package r_rom_pkg;

  localparam int R_ROM_BYTES = 8;

  typedef enum logic [1:0] {
    S_CMD = 2'd0,
    S_MEM = 2'd1,
    S_RSP = 2'd2
  } r_rom_state_t;

endpackage

// File: rtl/r_rom_shifter.sv
// Byte-wide right shift register with parallel load; a new byte enters at the top.
// Used both to assemble an address (byte in = FIFO data) and to serialize data (byte in = 0).
module r_rom_shifter #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_data,
  input  logic         i_shift,
  input  logic [7:0]   i_byte,
  output logic [W-1:0] o_data
);

  logic [W-1:0] r_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data <= '0;
    end else if (i_load) begin
      r_data <= i_load_data;
    end else if (i_shift) begin
      r_data <= {i_byte, r_data[W-1:8]};
    end
  end

  assign o_data = r_data;

endmodule

// File: rtl/r_rom_backend.sv
// ROM read backend: gathers a BYTES-wide address from the command FIFO (LSB first), reads
// the ROM, then streams the BYTES-wide result LSB first into the response FIFO.
module r_rom_backend
  import r_rom_pkg::*;
#(
  parameter int BYTES = R_ROM_BYTES,
  parameter int AW    = 8 * BYTES,
  parameter int DW    = 8 * BYTES
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          empty,
  output logic          rd_en,
  input  logic [7:0]    dout,
  input  logic          full,
  output logic          wr_en,
  output logic [7:0]    din,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam logic [3:0] LP_BYTES = 4'(BYTES);
  localparam logic [3:0] LP_LAST  = 4'(BYTES - 1);

  r_rom_state_t  r_state;
  logic [3:0]    r_req_cnt;
  logic [3:0]    r_cap_cnt;
  logic          r_rd_vld;

  logic          w_rd_fire;
  logic          w_wr_fire;
  logic          w_ack;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data;

  // Handshakes: a FIFO read happens on a cycle with rd_en=1 (only raised when empty=0),
  // its byte is on dout one cycle later; a FIFO write happens on any cycle with wr_en=1
  // (only raised when full=0); a ROM read completes on the first S_MEM cycle with mem_ack=1.
  assign w_rd_fire = rst_n & (r_state == S_CMD) & ~empty & (r_req_cnt < LP_BYTES);
  assign w_wr_fire = rst_n & (r_state == S_RSP) & ~full;
  assign w_ack     = (r_state == S_MEM) & mem_ack;

  // r_cap_cnt counts captured address bytes in S_CMD and written data bytes in S_RSP.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_CMD;
      r_req_cnt <= '0;
      r_cap_cnt <= '0;
      r_rd_vld  <= 1'b0;
    end else begin
      r_rd_vld <= w_rd_fire;
      case (r_state)
        S_CMD: begin
          if (w_rd_fire) r_req_cnt <= r_req_cnt + 4'd1;
          if (r_rd_vld) begin
            if (r_cap_cnt == LP_LAST) begin
              r_state   <= S_MEM;
              r_req_cnt <= '0;
              r_cap_cnt <= '0;
            end else begin
              r_cap_cnt <= r_cap_cnt + 4'd1;
            end
          end
        end
        S_MEM: begin
          if (mem_ack) begin
            r_state   <= S_RSP;
            r_cap_cnt <= '0;
          end
        end
        S_RSP: begin
          if (w_wr_fire) begin
            if (r_cap_cnt == LP_LAST) begin
              r_state   <= S_CMD;
              r_req_cnt <= '0;
              r_cap_cnt <= '0;
            end else begin
              r_cap_cnt <= r_cap_cnt + 4'd1;
            end
          end
        end
        default: r_state <= S_CMD;
      endcase
    end
  end

  r_rom_shifter #(.W(AW)) u_addr_deser (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load      (1'b0),
    .i_load_data ({AW{1'b0}}),
    .i_shift     (r_rd_vld),
    .i_byte      (dout),
    .o_data      (w_addr)
  );

  r_rom_shifter #(.W(DW)) u_data_ser (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load      (w_ack),
    .i_load_data (mem_rdata),
    .i_shift     (w_wr_fire),
    .i_byte      (8'h00),
    .o_data      (w_data)
  );

  assign rd_en    = w_rd_fire;
  assign wr_en    = w_wr_fire;
  assign din      = rst_n ? w_data[7:0] : 8'h00;
  assign mem_req  = rst_n & (r_state == S_MEM);
  assign mem_addr = rst_n ? w_addr : {AW{1'b0}};
  assign busy     = rst_n & ~((r_state == S_CMD) & (r_req_cnt == 4'd0));

endmodule
